// File: rtl/rxuart.sv
// 8N1 UART receiver with fractional baud-tick oversampling and start-edge resync.
// Optional RXUART_MAJORITY_EN: 2-of-3 majority vote around each mid-bit sample.
//
// state   | meaning
// IDLE    | waiting for a falling edge on an armed line
// START   | validating the start bit at its mid point
// DATA    | shifting in 8 data bits, LSB first
// STOP    | sampling the stop bit and delivering the byte
module rxuart #(
  parameter int CLK_HZ     = 16000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int ACC_W = $clog2(CLK_HZ) + 1;
  localparam int SUB_W = $clog2(OVERSAMPLE);
  localparam logic [ACC_W-1:0] ACC_INC = ACC_W'(BAUD * OVERSAMPLE);
  localparam logic [ACC_W-1:0] ACC_MOD = ACC_W'(CLK_HZ);

  // Sub-bit count seen on the tick that advances the counter to the decision point.
`ifdef RXUART_MAJORITY_EN
  localparam logic [SUB_W-1:0] TAP_A      = SUB_W'(OVERSAMPLE / 2 - 2);
  localparam logic [SUB_W-1:0] TAP_B      = SUB_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SUB_W-1:0] DECIDE_CNT = SUB_W'(OVERSAMPLE / 2);
`else
  localparam logic [SUB_W-1:0] DECIDE_CNT = SUB_W'(OVERSAMPLE / 2 - 1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           state, state_nxt;
  logic             rx_m, rx_s;
  logic [ACC_W-1:0] acc, acc_sum;
  logic             tick;
  logic [SUB_W-1:0] sub_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             armed;
  logic             bit_val;
  logic             sample_now;
  logic             clr_timing;
  logic             frame_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_uart_rx;
      rx_s <= rx_m;
    end
  end

  assign acc_sum    = acc + ACC_INC;
  assign tick       = (acc_sum >= ACC_MOD);
  assign sample_now = tick && (sub_cnt == DECIDE_CNT);

`ifdef RXUART_MAJORITY_EN
  logic smp_a, smp_b;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      smp_a <= 1'b1;
      smp_b <= 1'b1;
    end else if (tick) begin
      if (sub_cnt == TAP_A) smp_a <= rx_s;
      if (sub_cnt == TAP_B) smp_b <= rx_s;
    end
  end

  assign bit_val = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
`else
  assign bit_val = rx_s;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    clr_timing = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s && armed) begin
          state_nxt  = S_START;
          clr_timing = 1'b1;
        end
      end
      S_START: begin
        if (sample_now) state_nxt = bit_val ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (sample_now && (bit_cnt == 3'd7)) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (sample_now) begin
          state_nxt  = S_IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Tick phase restarts on every start edge so sampling tracks the sender.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc     <= '0;
      sub_cnt <= '0;
    end else if (clr_timing) begin
      acc     <= '0;
      sub_cnt <= '0;
    end else if (tick) begin
      acc     <= acc_sum - ACC_MOD;
      sub_cnt <= sub_cnt + 1'b1;
    end else begin
      acc     <= acc_sum;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bit_cnt <= '0;
      shift   <= '0;
    end else if (sample_now) begin
      if (state == S_START) bit_cnt <= '0;
      if (state == S_DATA) begin
        bit_cnt <= bit_cnt + 1'b1;
        shift   <= {bit_val, shift[7:1]};
      end
    end
  end

  // A held-low line must go high again before another start edge counts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                     armed <= 1'b0;
    else if (clr_timing)              armed <= 1'b0;
    else if (frame_done)              armed <= rx_s;
    else if ((state == S_IDLE) && rx_s) armed <= 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid <= frame_done;
      if (frame_done) begin
        o_data      <= shift;
        o_frame_err <= ~bit_val;
      end else begin
        o_frame_err <= 1'b0;
      end
    end
  end

  assign o_busy = (state != S_IDLE);

endmodule
